// File: rtl/dcache_load_align.sv
// Load-return alignment for the data cache. Each issued load leaves its metadata
// (offset, type, old rt) in a small FIFO. The in-order cache response is paired with
// that metadata and extracted, extended or merged for LWL/LWR. The result is then
// queued toward WB. Responses that belong to loads killed by a flush are counted and
// dropped.
module dcache_load_align #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_offset,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_rt,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_bytemask
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [2:0] TypeLw  = 3'b000;
   localparam logic [2:0] TypeLh  = 3'b001;
   localparam logic [2:0] TypeLhu = 3'b010;
   localparam logic [2:0] TypeLb  = 3'b011;
   localparam logic [2:0] TypeLbu = 3'b100;
   localparam logic [2:0] TypeLwl = 3'b101;
   localparam logic [2:0] TypeLwr = 3'b110;

   // Metadata FIFO storage
   logic [1:0]    r_meta_off  [DEPTH];
   logic [2:0]    r_meta_type [DEPTH];
   logic [31:0]   r_meta_rt   [DEPTH];
   logic [PW-1:0] r_meta_wptr;
   logic [PW-1:0] r_meta_rptr;
   logic [CW-1:0] r_meta_cnt;

   // Output queue storage
   logic [31:0]   r_oq_data [DEPTH];
   logic [3:0]    r_oq_mask [DEPTH];
   logic [PW-1:0] r_oq_wptr;
   logic [PW-1:0] r_oq_rptr;
   logic [CW-1:0] r_oq_cnt;

   // Responses still owed for killed loads
   logic [CW-1:0] r_drop_cnt;

   logic          w_push;
   logic          w_take;
   logic          w_drop;
   logic          w_pop;
   logic [CW+1:0] w_occ;
   logic [CW-1:0] w_meta_cnt_d;
   logic [CW-1:0] w_oq_cnt_d;
   logic [CW-1:0] w_drop_cnt_d;
   logic [CW:0]   w_owed;
   logic [1:0]    w_off;
   logic [2:0]    w_type;
   logic [31:0]   w_rt;
   logic [15:0]   w_half;
   logic [7:0]    w_byte;
   logic [31:0]   w_res_data;
   logic [3:0]    w_res_mask;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Occupancy and handshake decode; req_ready comes from registered counts only
   always_comb begin
      w_occ     = (CW+2)'(r_meta_cnt) + (CW+2)'(r_oq_cnt) + (CW+2)'(r_drop_cnt);
      req_ready = (w_occ < (CW+2)'(DEPTH));
      out_valid = (r_oq_cnt != '0);
      w_push    = req_valid && req_ready && !flush;
      w_drop    = rsp_valid && (r_drop_cnt != '0);
      // A response with no metadata cannot legally occur; guard so counts never wrap
      w_take    = rsp_valid && (r_drop_cnt == '0) && (r_meta_cnt != '0);
      w_pop     = out_valid && out_ready;
   end

   // Next-state counts, including the drop count loaded on flush
   always_comb begin
      w_owed = (CW+1)'(r_meta_cnt) + (CW+1)'(r_drop_cnt);
      if (rsp_valid && (w_owed != '0)) begin
         w_owed = w_owed - (CW+1)'(1);
      end
      if (flush) begin
         w_meta_cnt_d = '0;
         w_oq_cnt_d   = '0;
         w_drop_cnt_d = CW'(w_owed);
      end else begin
         w_meta_cnt_d = r_meta_cnt + CW'(w_push) - CW'(w_take);
         w_oq_cnt_d   = r_oq_cnt + CW'(w_take) - CW'(w_pop);
         w_drop_cnt_d = r_drop_cnt - CW'(w_drop);
      end
   end

   // Extract, extend or merge the returned word using the FIFO head metadata
   always_comb begin
      w_off      = r_meta_off[r_meta_rptr];
      w_type     = r_meta_type[r_meta_rptr];
      w_rt       = r_meta_rt[r_meta_rptr];
      w_half     = w_off[1] ? rsp_data[31:16] : rsp_data[15:0];
      w_byte     = rsp_data[7:0];
      w_res_data = rsp_data;
      w_res_mask = 4'b1111;
      unique case (w_off)
         2'd0: w_byte = rsp_data[7:0];
         2'd1: w_byte = rsp_data[15:8];
         2'd2: w_byte = rsp_data[23:16];
         2'd3: w_byte = rsp_data[31:24];
      endcase
      case (w_type)
         TypeLw:  w_res_data = rsp_data;
         TypeLh:  w_res_data = {{16{w_half[15]}}, w_half};
         TypeLhu: w_res_data = {16'h0000, w_half};
         TypeLb:  w_res_data = {{24{w_byte[7]}}, w_byte};
         TypeLbu: w_res_data = {24'h000000, w_byte};
         TypeLwl: begin
            unique case (w_off)
               2'd0: begin
                  w_res_data = {rsp_data[7:0], w_rt[23:0]};
                  w_res_mask = 4'b1000;
               end
               2'd1: begin
                  w_res_data = {rsp_data[15:0], w_rt[15:0]};
                  w_res_mask = 4'b1100;
               end
               2'd2: begin
                  w_res_data = {rsp_data[23:0], w_rt[7:0]};
                  w_res_mask = 4'b1110;
               end
               2'd3: begin
                  w_res_data = rsp_data;
                  w_res_mask = 4'b1111;
               end
            endcase
         end
         TypeLwr: begin
            unique case (w_off)
               2'd0: begin
                  w_res_data = rsp_data;
                  w_res_mask = 4'b1111;
               end
               2'd1: begin
                  w_res_data = {w_rt[31:24], rsp_data[31:8]};
                  w_res_mask = 4'b0111;
               end
               2'd2: begin
                  w_res_data = {w_rt[31:16], rsp_data[31:16]};
                  w_res_mask = 4'b0011;
               end
               2'd3: begin
                  w_res_data = {w_rt[31:8], rsp_data[31:24]};
                  w_res_mask = 4'b0001;
               end
            endcase
         end
         default: w_res_data = rsp_data;  // reserved type behaves as LW
      endcase
   end

   // Queue storage writes; contents are only observed through valid entries
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_meta_off[r_meta_wptr]  <= req_offset;
         r_meta_type[r_meta_wptr] <= req_type;
         r_meta_rt[r_meta_wptr]   <= req_rt;
      end
      if (w_take && !flush) begin
         r_oq_data[r_oq_wptr] <= w_res_data;
         r_oq_mask[r_oq_wptr] <= w_res_mask;
      end
   end

   // Pointers and counts with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_meta_wptr <= '0;
         r_meta_rptr <= '0;
         r_meta_cnt  <= '0;
         r_oq_wptr   <= '0;
         r_oq_rptr   <= '0;
         r_oq_cnt    <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_meta_cnt <= w_meta_cnt_d;
         r_oq_cnt   <= w_oq_cnt_d;
         r_drop_cnt <= w_drop_cnt_d;
         if (flush) begin
            r_meta_wptr <= '0;
            r_meta_rptr <= '0;
            r_oq_wptr   <= '0;
            r_oq_rptr   <= '0;
         end else begin
            if (w_push) r_meta_wptr <= ptr_inc(r_meta_wptr);
            if (w_take) r_meta_rptr <= ptr_inc(r_meta_rptr);
            if (w_take) r_oq_wptr   <= ptr_inc(r_oq_wptr);
            if (w_pop)  r_oq_rptr   <= ptr_inc(r_oq_rptr);
         end
      end
   end

   // Head of the output queue; forced to zero when empty so idle outputs read 0
   always_comb begin
      out_data     = out_valid ? r_oq_data[r_oq_rptr] : 32'h0;
      out_bytemask = out_valid ? r_oq_mask[r_oq_rptr] : 4'h0;
   end

endmodule

// File: tb/tb_dcache_load_align.sv
// Directed bench for dcache_load_align: expected results are queued when a response
// is driven and compared when WB accepts the head entry.
module tb_dcache_load_align;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_offset;
   logic [2:0]  req_type;
   logic [31:0] req_rt;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_bytemask;

   int checks;
   int failures;
   logic [35:0] sb[$];  // {mask, data}

   dcache_load_align #(.DEPTH(2)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_offset   (req_offset),
      .req_type     (req_type),
      .req_rt       (req_rt),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_bytemask (out_bytemask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference written from the byte-lane view rather than as a lookup table
   function automatic logic [35:0] model(input logic [2:0] t, input logic [1:0] o,
                                         input logic [31:0] rt, input logic [31:0] w);
      int sh;
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] d;
      logic [3:0]  m;
      sh = int'(o) * 8;
      h  = o[1] ? w[31:16] : w[15:0];
      b  = 8'(w >> sh);
      m  = 4'hF;
      case (t)
         3'd1: d = {{16{h[15]}}, h};
         3'd2: d = {16'h0, h};
         3'd3: d = {{24{b[7]}}, b};
         3'd4: d = {24'h0, b};
         3'd5: begin
            d = (w << (24 - sh)) | (rt & (32'hFFFFFFFF >> (sh + 8)));
            if (o == 2'd3) d = w;
            m = 4'(4'hF << (3 - int'(o)));
         end
         3'd6: begin
            d = (w >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
            m = 4'hF >> o;
         end
         default: d = w;
      endcase
      return {m, d};
   endfunction

   // Scoreboard: every accepted output must match the oldest expectation
   always @(negedge clk) begin
      if (resetn && out_valid && out_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_out: observed %h expected no output", out_data);
         end
         if (sb.size() != 0) begin
            logic [35:0] e;
            e = sb.pop_front();
            checks++;
            assert ({out_bytemask, out_data} === e) else begin
               failures++;
               $error("FAIL sb_out: observed %h expected %h", {out_bytemask, out_data}, e);
            end
         end
      end
   end

   // Issue one load, respond the next cycle and expect output one cycle later
   task automatic do_load(input logic [2:0] t, input logic [1:0] o, input logic [31:0] rt,
                          input logic [31:0] w, input logic [35:0] exp);
      req_valid  = 1'b1;
      req_type   = t;
      req_offset = o;
      req_rt     = rt;
      tick();
      req_valid = 1'b0;
      rsp_valid = 1'b1;
      rsp_data  = w;
      sb.push_back(exp);
      tick();
      rsp_valid = 1'b0;
      chk("latency_valid", 36'(out_valid), 36'd1);
      tick();
   endtask

   task automatic issue(input logic [2:0] t, input logic [31:0] w_unused);
      req_valid  = 1'b1;
      req_type   = t;
      req_offset = 2'd0;
      req_rt     = w_unused;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      resetn     = 1'b0;
      req_valid  = 1'b0;
      req_offset = 2'd0;
      req_type   = 3'd0;
      req_rt     = 32'h0;
      rsp_valid  = 1'b0;
      rsp_data   = 32'h0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      tick();
      tick();
      resetn = 1'b1;
      tick();
      chk("rst_out_valid", 36'(out_valid), 36'd0);
      chk("rst_out_data", 36'(out_data), 36'd0);
      chk("rst_bytemask", 36'(out_bytemask), 36'd0);
      chk("rst_req_ready", 36'(req_ready), 36'd1);

      // LB sweep and extension cases
      do_load(3'd3, 2'd0, 32'h0, 32'h80FF7F01, {4'hF, 32'h00000001});
      do_load(3'd3, 2'd1, 32'h0, 32'h80FF7F01, {4'hF, 32'h0000007F});
      do_load(3'd3, 2'd2, 32'h0, 32'h80FF7F01, {4'hF, 32'hFFFFFFFF});
      do_load(3'd3, 2'd3, 32'h0, 32'h80FF7F01, {4'hF, 32'hFFFFFF80});
      do_load(3'd4, 2'd3, 32'h0, 32'h80FF7F01, {4'hF, 32'h00000080});
      do_load(3'd1, 2'd2, 32'h0, 32'h80FF7F01, {4'hF, 32'hFFFF80FF});
      do_load(3'd2, 2'd2, 32'h0, 32'h80FF7F01, {4'hF, 32'h000080FF});
      do_load(3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, {4'b1100, 32'h3344CCDD});
      do_load(3'd6, 2'd2, 32'hAABBCCDD, 32'h11223344, {4'b0011, 32'hAABB1122});
      do_load(3'd5, 2'd0, 32'hAABBCCDD, 32'h11223344, {4'b1000, 32'h44BBCCDD});
      do_load(3'd6, 2'd3, 32'hAABBCCDD, 32'h11223344, {4'b0001, 32'hAABBCC11});
      do_load(3'd7, 2'd1, 32'hAABBCCDD, 32'h11223344, {4'hF, 32'h11223344});

      // Random loads against the model
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  t;
         logic [1:0]  o;
         logic [31:0] rt;
         logic [31:0] w;
         t  = 3'($urandom_range(0, 7));
         o  = 2'($urandom);
         rt = $urandom;
         w  = $urandom;
         do_load(t, o, rt, w, model(t, o, rt, w));
      end

      // Backpressure: two LW results held while WB stalls
      out_ready = 1'b0;
      issue(3'd0, 32'h0);
      tick();
      issue(3'd0, 32'h0);
      rsp_valid = 1'b1;
      rsp_data  = 32'hA0A0A0A0;
      sb.push_back({4'hF, 32'hA0A0A0A0});
      tick();
      req_valid = 1'b0;
      rsp_data  = 32'hB1B1B1B1;
      sb.push_back({4'hF, 32'hB1B1B1B1});
      tick();
      rsp_valid = 1'b0;
      chk("bp_req_ready", 36'(req_ready), 36'd0);
      chk("bp_out_valid", 36'(out_valid), 36'd1);
      chk("bp_head", 36'(out_data), 36'hA0A0A0A0);
      tick();
      chk("bp_stable", 36'(out_data), 36'hA0A0A0A0);
      chk("bp_still_full", 36'(req_ready), 36'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", 36'(req_ready), 36'd1);
      chk("bp_second", 36'(out_data), 36'hB1B1B1B1);
      tick();
      chk("bp_drained", 36'(out_valid), 36'd0);

      // Flush with loads pending: responses discarded, capacity held until dropped
      issue(3'd0, 32'h0);
      tick();
      issue(3'd0, 32'h0);
      tick();
      req_valid = 1'b0;
      flush     = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_req_ready", 36'(req_ready), 36'd0);
      chk("fl_out_valid", 36'(out_valid), 36'd0);
      tick();
      rsp_valid = 1'b1;
      rsp_data  = 32'hDEAD0001;
      tick();
      rsp_valid = 1'b0;
      chk("fl_drop1_valid", 36'(out_valid), 36'd0);
      chk("fl_drop1_ready", 36'(req_ready), 36'd1);
      rsp_valid = 1'b1;
      rsp_data  = 32'hDEAD0002;
      tick();
      rsp_valid = 1'b0;
      chk("fl_drop2_valid", 36'(out_valid), 36'd0);
      do_load(3'd1, 2'd0, 32'h0, 32'h12348765, {4'hF, 32'hFFFF8765});

      // Flush coincident with a response and a new request
      issue(3'd0, 32'h0);
      tick();
      issue(3'd0, 32'h0);
      tick();
      flush     = 1'b1;
      rsp_valid = 1'b1;
      rsp_data  = 32'hDEAD0003;
      issue(3'd3, 32'h0);
      tick();
      flush     = 1'b0;
      rsp_valid = 1'b0;
      req_valid = 1'b0;
      chk("fc_out_valid", 36'(out_valid), 36'd0);
      chk("fc_one_owed", 36'(req_ready), 36'd1);
      // New load: its response must follow the one still owed
      issue(3'd4, 32'h0);
      req_offset = 2'd1;
      tick();
      req_valid = 1'b0;
      chk("fc_full", 36'(req_ready), 36'd0);
      rsp_valid = 1'b1;
      rsp_data  = 32'hDEAD0004;
      tick();
      chk("fc_dropped", 36'(out_valid), 36'd0);
      rsp_data = 32'h0000C300;
      sb.push_back({4'hF, 32'h000000C3});
      tick();
      rsp_valid = 1'b0;
      chk("fc_new_valid", 36'(out_valid), 36'd1);
      tick();

      // Reset mid-stream with two queued entries
      out_ready = 1'b0;
      issue(3'd0, 32'h0);
      tick();
      issue(3'd0, 32'h0);
      rsp_valid = 1'b1;
      rsp_data  = 32'h01010101;
      tick();
      req_valid = 1'b0;
      rsp_data  = 32'h02020202;
      tick();
      rsp_valid = 1'b0;
      chk("rs_full", 36'(req_ready), 36'd0);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      chk("rs_out_valid", 36'(out_valid), 36'd0);
      chk("rs_req_ready", 36'(req_ready), 36'd1);
      chk("rs_out_data", 36'(out_data), 36'd0);
      out_ready = 1'b1;
      tick();
      do_load(3'd0, 2'd2, 32'h0, 32'hCAFEF00D, {4'hF, 32'hCAFEF00D});

      tick();
      chk("sb_empty", 36'(sb.size()), 36'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
